commit_trace_collector: RTL

Buffers retired-instruction trace records from the two commit ports and presents them, one per cycle and in program order, on a valid/ready stream. It sits directly downstream of the commit stage's tracer taps: commit acknowledge, PC, instruction word, exception and privilege level. Its output feeds the trace encoder / off-core trace sink. Sequence numbering and a drop counter let the consumer detect lost records when it back-pressures too long.

---
 rtl/commit_trace_collector.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/commit_trace_collector.sv
// commit_trace_collector
//
// Buffers retired-instruction trace records from a two-wide commit stage.
// Records leave one per cycle, in program order, on a first-word
// fall-through valid/ready stream. Every committed instruction consumes a
// sequence number, including those that are lost. A saturating drop counter
// lets the consumer see how many records were lost to overflow.
//
// Handshake: a record transfers on a rising edge where trace_valid_o and
// trace_ready_i are both 1. While trace_valid_o=1 and trace_ready_i=0, every
// trace_*_o output holds its value. trace_valid_o never depends on
// trace_ready_i in the same cycle.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   clear_i             flush buffered records; seq and drop counters kept
//   commit_valid_i[1:0] per-port commit acknowledge (port 0 is older)
//   commit_pc_i         {pc1, pc0}, 64 bits each
//   commit_instr_i      {instr1, instr0}, 32 bits each
//   commit_ex_i[1:0]    per-port exception flag
//   commit_cause_i      {cause1, cause0}, 64 bits each
//   priv_lvl_i          privilege level shared by both ports
//   trace_valid_o/ready_i  output stream handshake
//   trace_pc_o, trace_instr_o, trace_ex_o, trace_cause_o, trace_priv_o,
//   trace_seq_o         fields of the head record
//   drop_cnt_o          saturating count of records lost to overflow
//   full_o              buffer holds DEPTH records
module commit_trace_collector #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [1:0]       commit_valid_i,
    input  logic [127:0]     commit_pc_i,
    input  logic [63:0]      commit_instr_i,
    input  logic [1:0]       commit_ex_i,
    input  logic [127:0]     commit_cause_i,
    input  logic [1:0]       priv_lvl_i,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [63:0]      trace_pc_o,
    output logic [31:0]      trace_instr_o,
    output logic             trace_ex_o,
    output logic [63:0]      trace_cause_o,
    output logic [1:0]       trace_priv_o,
    output logic [SEQ_W-1:0] trace_seq_o,
    output logic [SEQ_W-1:0] drop_cnt_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Record storage
    logic [63:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic             ex_q    [DEPTH];
    logic [63:0]      cause_q [DEPTH];
    logic [1:0]       priv_q  [DEPTH];
    logic [SEQ_W-1:0] seqn_q  [DEPTH];

    logic [PW-1:0]    rd_ptr_q, wr_ptr_q, count_q;
    logic [SEQ_W-1:0] seq_q, drop_q;

    logic [1:0]       n_valid;
    logic [PW-1:0]    free_w;
    logic             wr_a, wr_b, pop;
    logic [PW-1:0]    written;
    logic [1:0]       dropped;
    logic [SEQ_W:0]   drop_sum;
    logic [SEQ_W-1:0] drop_d;
    logic [AW-1:0]    idx_a, idx_b, rd_idx;

    // Record A is the older valid one (port 0 if valid, otherwise port 1).
    // Record B exists only when both ports commit, and is always port 1.
    logic             sel_a;
    logic [63:0]      pc_a, cause_a;
    logic [31:0]      instr_a;
    logic             ex_a;

    always_comb begin
        n_valid = {1'b0, commit_valid_i[0]} + {1'b0, commit_valid_i[1]};
        // Space comes from the registered count only; a pop in this cycle
        // does not make room for this cycle's commits.
        free_w  = PW'(DEPTH) - count_q;
        wr_a    = !clear_i && (n_valid != 2'd0) && (free_w >= PW'(1));
        wr_b    = !clear_i && (n_valid == 2'd2) && (free_w >= PW'(2));
        pop     = (count_q != '0) && trace_ready_i;
        written = PW'(wr_a) + PW'(wr_b);
        // Commits discarded by clear_i are not counted as drops.
        dropped = clear_i ? 2'd0 : (n_valid - {1'b0, wr_a} - {1'b0, wr_b});

        drop_sum = {1'b0, drop_q} + (SEQ_W + 1)'(dropped);
        drop_d   = drop_sum[SEQ_W] ? '1 : drop_sum[SEQ_W-1:0];

        sel_a   = !commit_valid_i[0];
        pc_a    = sel_a ? commit_pc_i[127:64]    : commit_pc_i[63:0];
        instr_a = sel_a ? commit_instr_i[63:32]  : commit_instr_i[31:0];
        ex_a    = sel_a ? commit_ex_i[1]         : commit_ex_i[0];
        cause_a = sel_a ? commit_cause_i[127:64] : commit_cause_i[63:0];

        idx_a  = wr_ptr_q[AW-1:0];
        idx_b  = idx_a + AW'(1);
        rd_idx = rd_ptr_q[AW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                ex_q[i]    <= 1'b0;
                cause_q[i] <= '0;
                priv_q[i]  <= '0;
                seqn_q[i]  <= '0;
            end
        end else begin
            // Numbers are consumed whether a record is stored, dropped or
            // discarded by a clear.
            seq_q  <= seq_q + SEQ_W'(n_valid);
            drop_q <= drop_d;

            if (clear_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_q + PW'(pop);
                wr_ptr_q <= wr_ptr_q + written;
                count_q  <= count_q + written - PW'(pop);
            end

            if (wr_a) begin
                pc_q[idx_a]    <= pc_a;
                instr_q[idx_a] <= instr_a;
                ex_q[idx_a]    <= ex_a;
                cause_q[idx_a] <= cause_a;
                priv_q[idx_a]  <= priv_lvl_i;
                seqn_q[idx_a]  <= seq_q;
            end
            if (wr_b) begin
                pc_q[idx_b]    <= commit_pc_i[127:64];
                instr_q[idx_b] <= commit_instr_i[63:32];
                ex_q[idx_b]    <= commit_ex_i[1];
                cause_q[idx_b] <= commit_cause_i[127:64];
                priv_q[idx_b]  <= priv_lvl_i;
                seqn_q[idx_b]  <= seq_q + SEQ_W'(1);
            end
        end
    end

    // Head record read through the registered read pointer.
    assign trace_valid_o = (count_q != '0);
    assign trace_pc_o    = pc_q[rd_idx];
    assign trace_instr_o = instr_q[rd_idx];
    assign trace_ex_o    = ex_q[rd_idx];
    assign trace_cause_o = cause_q[rd_idx];
    assign trace_priv_o  = priv_q[rd_idx];
    assign trace_seq_o   = seqn_q[rd_idx];
    assign drop_cnt_o    = drop_q;
    assign full_o        = (count_q == PW'(DEPTH));

endmodule
